// File: rtl/nios2_system_onchip_memory_dp.sv
`default_nettype none
// ============================================================================
// Module      : nios2_system_onchip_memory_dp
// Description : Dual-port on-chip RAM with two independent Avalon-MM slaves.
//               Pipelined reads (latency 1 or 2) with readdatavalid,
//               waitrequest stalling on clken, write-first cross-port
//               forwarding, s1-priority byte-lane write collisions and an
//               optional post-reset zero-fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
// INIT_FILE names a hex image for the array when CLEAR_ON_RESET=0; it is
// applied by the target device's memory initialisation flow, not by logic here.
module nios2_system_onchip_memory_dp #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 16,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter     INIT_FILE      = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clken,
    // port 1 (Nios II data master)
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    // port 2 (DMA / video side)
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                init_done
);

    localparam int c_depth = 2 ** ADDR_W;
    localparam int c_lanes = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [ADDR_W-1:0]   w_clr_addr_nxt;
    logic [DATA_W-1:0]   r_mem [0:c_depth-1];

    // Both ports packed side by side: index 0 is s1, index 1 is s2.
    logic [1:0][ADDR_W-1:0]  w_addr;
    logic [1:0][c_lanes-1:0] w_be;
    logic [1:0][DATA_W-1:0]  w_wdata;
    logic [1:0]              w_cs;
    logic [1:0]              w_rd;
    logic [1:0]              w_wr;
    logic [1:0]              w_acc;
    logic [1:0]              w_do_wr;
    logic [1:0]              w_do_rd;
    logic                    w_run;
    logic                    w_wait;
    logic                    w_clr_we;

    assign w_addr  = {s2_address,    s1_address};
    assign w_be    = {s2_byteenable, s1_byteenable};
    assign w_wdata = {s2_writedata,  s1_writedata};
    assign w_cs    = {s2_chipselect, s1_chipselect};
    assign w_rd    = {s2_read,       s1_read};
    assign w_wr    = {s2_write,      s1_write};

    // Reset is folded in so the bus sees a stalled, not-ready memory while
    // reset_n is low, even when the state register resets straight to RUN.
    assign w_run     = reset_n & (r_state == ST_RUN);
    assign w_wait    = ~(w_run & clken);
    assign w_clr_we  = reset_n & (r_state == ST_CLEAR) & clken;

    // Read together with write on one port is a plain write.
    assign w_acc   = w_cs & (w_rd | w_wr) & {2{~w_wait}};
    assign w_do_wr = w_acc & w_wr;
    assign w_do_rd = w_acc & w_rd & ~w_wr;

    assign s1_waitrequest = w_wait;
    assign s2_waitrequest = w_wait;
    assign init_done      = w_run;

    // State and clear-address register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_reset_state;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Zero-fill sequencing: one word per enabled cycle, RUN after the last word.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        if (r_state == ST_CLEAR && clken) begin
            w_clr_addr_nxt = r_clr_addr + 1'b1;
            if (r_clr_addr == {ADDR_W{1'b1}}) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    // Array update; s1 lanes are applied last so s1 wins a same-word collision.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= '0;
        end
        for (int l = 0; l < c_lanes; l++) begin
            if (w_do_wr[1] && w_be[1][l]) begin
                r_mem[w_addr[1]][8*l +: 8] <= w_wdata[1][8*l +: 8];
            end
            if (w_do_wr[0] && w_be[0][l]) begin
                r_mem[w_addr[0]][8*l +: 8] <= w_wdata[0][8*l +: 8];
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int c_other = 1 - p;

        logic [DATA_W-1:0] w_fwd;
        logic              w_stage_valid;
        logic [DATA_W-1:0] w_stage_data;
        logic              r_valid;
        logic [DATA_W-1:0] r_data;

        // Word seen by this port: array contents with the other port's
        // same-cycle write lanes forwarded in (write-first).
        always_comb begin
            w_fwd = r_mem[w_addr[p]];
            for (int l = 0; l < c_lanes; l++) begin
                if (w_do_wr[c_other] && (w_addr[c_other] == w_addr[p]) && w_be[c_other][l]) begin
                    w_fwd[8*l +: 8] = w_wdata[c_other][8*l +: 8];
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic              r_p1_valid;
            logic [DATA_W-1:0] r_p1_data;

            // First pipeline stage, frozen while clken is low.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_p1_valid <= 1'b0;
                    r_p1_data  <= '0;
                end else if (clken) begin
                    r_p1_valid <= w_do_rd[p];
                    if (w_do_rd[p]) begin
                        r_p1_data <= w_fwd;
                    end
                end
            end

            assign w_stage_valid = r_p1_valid;
            assign w_stage_data  = r_p1_data;
        end else begin : g_lat1
            assign w_stage_valid = w_do_rd[p];
            assign w_stage_data  = w_fwd;
        end

        // Output stage; readdata only moves when a new word is delivered.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (clken) begin
                r_valid <= w_stage_valid;
                if (w_stage_valid) begin
                    r_data <= w_stage_data;
                end
            end
        end
    end

    assign s1_readdata      = g_port[0].r_data;
    assign s1_readdatavalid = g_port[0].r_valid;
    assign s2_readdata      = g_port[1].r_data;
    assign s2_readdatavalid = g_port[1].r_valid;

endmodule
`default_nettype wire

// File: tb/tb_nios2_system_onchip_memory_dp.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_system_onchip_memory_dp
// Description : Directed self-checking bench for the dual-port on-chip RAM
//               (ADDR_W=4, READ_LATENCY=2, CLEAR_ON_RESET=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_system_onchip_memory_dp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clken;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s2_chipselect;
    logic          s1_read, s2_read;
    logic          s1_write, s2_write;
    logic [BW-1:0] s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata;
    logic [DW-1:0] s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid;
    logic          s1_waitrequest, s2_waitrequest;
    logic          init_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nios2_system_onchip_memory_dp #(
        .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
        .s2_waitrequest(s2_waitrequest),
        .init_done(init_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    endtask

    task automatic s1_cmd(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [BW-1:0] be, input logic [DW-1:0] d);
        s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
    endtask

    task automatic s2_cmd(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [BW-1:0] be, input logic [DW-1:0] d);
        s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = d;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 0; clken = 1; idle();
        repeat (3) @(posedge clk);
        #1;
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_s1_rdv got=%b exp=0", s1_readdatavalid); end
        total++; if (s2_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_s2_rdv got=%b exp=0", s2_readdatavalid); end
        total++; if (s1_readdata !== 32'h0) begin bad++; $display("FAIL reset_s1_rdata got=%h exp=0", s1_readdata); end
        total++; if (s2_readdata !== 32'h0) begin bad++; $display("FAIL reset_s2_rdata got=%h exp=0", s2_readdata); end
        total++; if (s1_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_s1_wait got=%b exp=1", s1_waitrequest); end
        total++; if (s2_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_s2_wait got=%b exp=1", s2_waitrequest); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
        // A write attempted during the clear must be ignored.
        s1_cmd(0, 1, 4'd5, 4'hF, 32'hFFFF_FFFF);
        reset_n = 1;
        n = 0;
        while (s1_waitrequest === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        idle();
        total++; if (n !== 16) begin bad++; $display("FAIL clear_cycles got=%0d exp=16", n); end
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL clear_init_done got=%b exp=1", init_done); end
        total++; if (s2_waitrequest !== 1'b0) begin bad++; $display("FAIL run_s2_wait got=%b exp=0", s2_waitrequest); end
    endtask

    task automatic test_clear_read();
        s1_cmd(1, 0, 4'd5, 4'hF, 32'h0);
        tick();
        idle();
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL clr_rd_early got=%b exp=0", s1_readdatavalid); end
        tick();
        total++; if (s1_readdatavalid !== 1'b1) begin bad++; $display("FAIL clr_rd_valid got=%b exp=1", s1_readdatavalid); end
        total++; if (s1_readdata !== 32'h0) begin bad++; $display("FAIL clr_rd_data got=%h exp=00000000", s1_readdata); end
        tick();
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL clr_rd_single got=%b exp=0", s1_readdatavalid); end
    endtask

    task automatic test_pipeline();
        s1_cmd(0, 1, 4'd3, 4'hF, 32'hDEAD_BEEF); tick();
        s1_cmd(1, 0, 4'd3, 4'hF, 32'h0);         tick();
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL pipe_c1 got=%b exp=0", s1_readdatavalid); end
        s1_cmd(1, 0, 4'd4, 4'hF, 32'h0);         tick();
        total++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pipe_c2 got=%b/%h exp=1/deadbeef", s1_readdatavalid, s1_readdata); end
        s1_cmd(1, 0, 4'd3, 4'hF, 32'h0);         tick();
        total++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h0) begin bad++; $display("FAIL pipe_c3 got=%b/%h exp=1/00000000", s1_readdatavalid, s1_readdata); end
        idle();                                  tick();
        total++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pipe_c4 got=%b/%h exp=1/deadbeef", s1_readdatavalid, s1_readdata); end
        tick();
        total++; if (s1_readdatavalid !== 1'b0 || s1_readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pipe_hold got=%b/%h exp=0/deadbeef", s1_readdatavalid, s1_readdata); end
    endtask

    task automatic test_byte_lanes();
        s1_cmd(0, 1, 4'd9, 4'hF, 32'h1122_3344); tick();
        s1_cmd(0, 1, 4'd9, 4'h5, 32'hAABB_CCDD); tick();
        s1_cmd(0, 1, 4'd9, 4'h0, 32'hFFFF_FFFF); tick();
        idle();
        s2_cmd(1, 0, 4'd9, 4'hF, 32'h0);         tick();
        idle();                                  tick();
        total++; if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'h11BB_33DD) begin bad++; $display("FAIL byte_lanes got=%b/%h exp=1/11bb33dd", s2_readdatavalid, s2_readdata); end
    endtask

    task automatic test_collision();
        s1_cmd(0, 1, 4'd7, 4'hC, 32'hFFFF_0000);
        s2_cmd(0, 1, 4'd7, 4'hF, 32'h1234_5678); tick();
        idle();
        s1_cmd(1, 0, 4'd7, 4'hF, 32'h0);         tick();
        idle();                                  tick();
        total++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'hFFFF_5678) begin bad++; $display("FAIL coll_ww got=%b/%h exp=1/ffff5678", s1_readdatavalid, s1_readdata); end
        s1_cmd(0, 1, 4'd10, 4'hF, 32'hCAFE_F00D);
        s2_cmd(1, 0, 4'd10, 4'hF, 32'h0);        tick();
        idle();                                  tick();
        total++; if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL coll_wr_full got=%b/%h exp=1/cafef00d", s2_readdatavalid, s2_readdata); end
        s1_cmd(0, 1, 4'd7, 4'h3, 32'h0000_BEEF);
        s2_cmd(1, 0, 4'd7, 4'hF, 32'h0);         tick();
        idle();                                  tick();
        total++; if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'hFFFF_BEEF) begin bad++; $display("FAIL coll_wr_part got=%b/%h exp=1/ffffbeef", s2_readdatavalid, s2_readdata); end
        // read and write together on one port behave as a write only
        s1_cmd(1, 1, 4'd11, 4'hF, 32'h0000_0055); tick();
        idle();                                   tick();
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rw_no_rdv1 got=%b exp=0", s1_readdatavalid); end
        tick();
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rw_no_rdv2 got=%b exp=0", s1_readdatavalid); end
        s2_cmd(1, 0, 4'd11, 4'hF, 32'h0);         tick();
        idle();                                   tick();
        total++; if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'h0000_0055) begin bad++; $display("FAIL rw_written got=%b/%h exp=1/00000055", s2_readdatavalid, s2_readdata); end
    endtask

    task automatic test_clken_stall();
        s1_cmd(1, 0, 4'd3, 4'hF, 32'h0); tick();
        idle();
        clken = 0;
        #1;
        total++; if (s1_waitrequest !== 1'b1) begin bad++; $display("FAIL stall_wait got=%b exp=1", s1_waitrequest); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL stall_rdv_%0d got=%b exp=0", i, s1_readdatavalid); end
        end
        clken = 1;
        tick();
        total++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stall_late got=%b/%h exp=1/deadbeef", s1_readdatavalid, s1_readdata); end
        tick();
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL stall_after got=%b exp=0", s1_readdatavalid); end
        // valid asserted when clken drops must hold with its data
        s1_cmd(1, 0, 4'd9, 4'hF, 32'h0); tick();
        idle();                          tick();
        clken = 0;
        tick(); tick();
        total++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h11BB_33DD) begin bad++; $display("FAIL freeze_hold got=%b/%h exp=1/11bb33dd", s1_readdatavalid, s1_readdata); end
        clken = 1;
        tick();
        total++; if (s1_readdatavalid !== 1'b0) begin bad++; $display("FAIL freeze_release got=%b exp=0", s1_readdatavalid); end
    endtask

    task automatic test_reset_midread();
        int n;
        s1_cmd(1, 0, 4'd3, 4'hF, 32'h0); tick();
        idle();
        reset_n = 0;
        #1;
        total++; if (init_done !== 1'b0 || s1_waitrequest !== 1'b1) begin bad++; $display("FAIL mid_reset_state got=%b/%b exp=0/1", init_done, s1_waitrequest); end
        tick();
        total++; if (s1_readdatavalid !== 1'b0 || s1_readdata !== 32'h0) begin bad++; $display("FAIL mid_reset_drop got=%b/%h exp=0/00000000", s1_readdatavalid, s1_readdata); end
        reset_n = 1;
        n = 0;
        while (s1_waitrequest === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++; if (n !== 16) begin bad++; $display("FAIL reclear_cycles got=%0d exp=16", n); end
        s1_cmd(1, 0, 4'd3, 4'hF, 32'h0); tick();
        idle();                          tick();
        total++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h0) begin bad++; $display("FAIL reclear_data got=%b/%h exp=1/00000000", s1_readdatavalid, s1_readdata); end
    endtask

    initial begin
        test_reset();
        test_clear_read();
        test_pipeline();
        test_byte_lanes();
        test_collision();
        test_clken_stall();
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/nios2_system_onchip_memory_dp.md
Name: nios2_system_onchip_memory_dp

Overview:
Parametrised dual-port on-chip RAM with two independent Avalon-MM slaves (s1 for the Nios II data master, s2 for the DMA/video side). It adds pipelined reads with readdatavalid, selectable read latency, waitrequest-based stalling, cross-port collision resolution and an optional post-reset zero-fill engine. It sits on the system interconnect as a drop-in, wider and deeper memory.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 16, word address width; depth = 2**ADDR_W words.
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values are 1 or 2.
CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset before accepting traffic.
INIT_FILE, "", hex preload file. Used only when CLEAR_ON_RESET=0.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clken  in  1  global clock enable; low stalls both ports
s1_address  in  ADDR_W  port 1 word address
s1_chipselect  in  1  port 1 select
s1_read  in  1  port 1 read request
s1_write  in  1  port 1 write request
s1_byteenable  in  DATA_W/8  port 1 byte lanes
s1_writedata  in  DATA_W  port 1 write data
s1_readdata  out  DATA_W  port 1 read data
s1_readdatavalid  out  1  port 1 read data valid
s1_waitrequest  out  1  port 1 stall
s2_*  same set as s1_*, for port 2
init_done  out  1  high once the array is usable

Behaviour:
- Reset (reset_n low, asynchronous):
  - readdata = 0 and readdatavalid = 0 on both ports.
  - waitrequest = 1 on both ports.
  - init_done = 0.
  - In-flight reads are discarded.
  - FSM enters CLEAR if CLEAR_ON_RESET=1, else RUN.
- FSM CLEAR:
  - A clear counter starts at 0 and writes all-zero data to every byte lane each cycle clken=1.
  - Counter holds while clken=0.
  - After address 2**ADDR_W-1 is written, the next edge moves to RUN. Total = 2**ADDR_W enabled cycles.
  - Both waitrequests stay 1 throughout; requests are ignored.
- FSM RUN:
  - init_done = 1. RUN is terminal until reset.
  - waitrequest = ~clken, combinational.
- Acceptance: a port transfer is accepted on an edge where chipselect & (read | write) & ~waitrequest.
- Writes:
  - Written on the accept edge, only in lanes where byteenable=1.
  - byteenable=0 on a write is a legal no-op.
- Reads:
  - readdatavalid pulses exactly READ_LATENCY enabled cycles after accept, with the array word at accept time.
  - Back-to-back reads are fully pipelined: one per cycle, data returned in order.
  - When clken=0 the read pipeline freezes; readdata and readdatavalid hold.
- read and write asserted together on one port: treated as a write only; no readdatavalid.
- Same-port read-during-write (write accepted earlier in the same cycle sequence): a read accepted the cycle after a write to the same address returns the new data.
- Cross-port collisions, same cycle, same address:
  - Both write: per byte lane, s1 wins where s1_byteenable=1; s2 lanes not enabled by s1 are written.
  - One reads while the other writes: the reader gets the new data for written lanes and old data for the other lanes (write-first forwarding).
- readdata outside a readdatavalid pulse holds its last value.
- Reset asserted mid-read or mid-clear: pending readdatavalid pulses are dropped. Clear restarts from address 0 after reset release.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_W=4: release reset, clken=1 -> waitrequest=1 for 16 cycles; init_done rises on cycle 16; a later s1 read of address 5 returns 0x00000000 with one readdatavalid pulse.
- READ_LATENCY=2: s1 writes 0xDEADBEEF to address 3, then reads 3, 4, 3 on consecutive cycles -> readdatavalid on cycles +2, +3, +4, with data 0xDEADBEEF, 0x0, 0xDEADBEEF.
- Byte lanes: write 0x11223344 with byteenable 4'b1111, then write 0xAABBCCDD with byteenable 4'b0101 -> readback 0x11BB33DD.
- Collision: same cycle at address 7, s1 writes 0xFFFF0000 with byteenable 4'b1100 and s2 writes 0x12345678 with byteenable 4'b1111 -> address 7 holds 0xFFFF5678. Separately, s1 write plus s2 read of the same address -> s2 receives the new word.
- clken low for 3 cycles with a read in flight -> waitrequest=1, readdatavalid delayed by exactly 3 cycles, data unchanged.
- Assert reset_n low one cycle after a read accept -> no readdatavalid; init_done=0; clear restarts from address 0.
